// File: rtl/fp_pkg.sv
// Shared definitions for the 8-bit floating-point divider: format widths,
// reserved exponent codes and the controller state encoding.
package fp_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;

  // Exponent 0000 encodes zero (mantissa ignored); 1111 is the saturated
  // code used for divide-by-zero and overflow results.
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_INF  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare remainder against divisor,
// emit a quotient bit and produce the shifted next remainder.
module div_step #(
  parameter int RW = fp_pkg::MAN_W + 2
) (
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] my,
  output logic          qbit,
  output logic [RW-1:0] r_next
);

  logic [RW-1:0] diff;

  // The remainder is always below 2*MY, so the shifted value fits in RW bits.
  always_comb begin
    qbit   = (r >= my);
    diff   = r - my;
    r_next = qbit ? (diff << 1) : (r << 1);
  end

endmodule

// File: rtl/fp_div8.sv
// Multi-cycle floating-point divider for {sign, exp, man} operands with a
// hidden leading one, truncating quotient and saturating exponent range.
module fp_div8 #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int BIAS  = fp_pkg::BIAS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   of,
  output logic                   dz
);

  import fp_pkg::*;

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic [2:0]           LAST_ITER = 3'(RW - 1);
  localparam logic signed [EW-1:0] E_MIN     = EW'(1);
  localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] E_BIAS    = EW'(BIAS);

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic              sign_reg;
  logic [EXP_W-1:0]  xe_reg;
  logic [EXP_W-1:0]  ye_reg;
  logic [RW-1:0]     r_reg;
  logic [RW-1:0]     my_reg;
  logic [RW-2:0]     q_reg;
  logic [W-1:0]      z_reg;
  logic              of_reg;
  logic              dz_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;

  logic              sign_in;
  logic [EXP_W-1:0]  xe_in;
  logic [EXP_W-1:0]  ye_in;
  logic [MAN_W-1:0]  xm_in;
  logic [MAN_W-1:0]  ym_in;

  assign sign_in = x[W-1] ^ y[W-1];
  assign xe_in   = x[W-2:MAN_W];
  assign ye_in   = y[W-2:MAN_W];
  assign xm_in   = x[MAN_W-1:0];
  assign ym_in   = y[MAN_W-1:0];

  logic              step_bit;
  logic [RW-1:0]     step_r;

  div_step #(
    .RW(RW)
  ) u_step (
    .r      (r_reg),
    .my     (my_reg),
    .qbit   (step_bit),
    .r_next (step_r)
  );

  logic [RW-1:0]         q_final;
  logic signed [EW-1:0]  e_base;
  logic signed [EW-1:0]  e_norm;
  logic [MAN_W-1:0]      man_norm;
  logic [W-1:0]          z_norm;
  logic                  of_norm;

  // Normalisation sees the final quotient bit combinationally so the result
  // is registered on the same edge as the last iteration.
  always_comb begin
    q_final = {q_reg, step_bit};
    e_base  = $signed({2'b00, xe_reg}) - $signed({2'b00, ye_reg}) + E_BIAS;
    if (q_final[RW-1]) begin
      man_norm = q_final[RW-2:1];
      e_norm   = e_base;
    end else begin
      man_norm = q_final[RW-3:0];
      e_norm   = e_base - E_MIN;
    end
    if (e_norm > E_MAX) begin
      z_norm  = {sign_reg, EXP_INF, {MAN_W{1'b0}}};
      of_norm = 1'b1;
    end else if (e_norm < E_MIN) begin
      z_norm  = {sign_reg, {(W-1){1'b0}}};
      of_norm = 1'b1;
    end else begin
      z_norm  = {sign_reg, e_norm[EXP_W-1:0], man_norm};
      of_norm = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      sign_reg      <= 1'b0;
      xe_reg        <= '0;
      ye_reg        <= '0;
      r_reg         <= '0;
      my_reg        <= '0;
      q_reg         <= '0;
      z_reg         <= '0;
      of_reg        <= 1'b0;
      dz_reg        <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            sign_reg     <= sign_in;
            xe_reg       <= xe_in;
            ye_reg       <= ye_in;
            r_reg        <= {1'b0, 1'b1, xm_in};
            my_reg       <= {1'b0, 1'b1, ym_in};
            q_reg        <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            // A zero divisor wins over a zero dividend.
            if (ye_in == EXP_ZERO) begin
              z_reg         <= {sign_in, EXP_INF, {MAN_W{1'b0}}};
              of_reg        <= 1'b0;
              dz_reg        <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end else if (xe_in == EXP_ZERO) begin
              z_reg         <= {sign_in, {(W-1){1'b0}}};
              of_reg        <= 1'b0;
              dz_reg        <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end else begin
              state_reg     <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          r_reg   <= step_r;
          q_reg   <= q_final[RW-2:0];
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == LAST_ITER) begin
            z_reg         <= z_norm;
            of_reg        <= of_norm;
            dz_reg        <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign z         = z_reg;
  assign of        = of_reg;
  assign dz        = dz_reg;

endmodule

// File: tb/tb_fp_div8.sv
// Directed-vector bench for fp_div8: reset, quotients, zero operands,
// exponent limits, output stall and mid-operation reset.
module tb_fp_div8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic       of;
  logic       dz;

  int n_checks = 0;
  int n_pass   = 0;

  fp_div8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .of        (of),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic       of_e;
    logic       dz_e;
    logic [3:0] lat;
  } vec_t;

  // lat = edges from the capture edge to the first edge that samples out_valid high
  vec_t div_tbl [0:4] = '{
    '{8'h44, 8'h3C, 8'h40, 1'b0, 1'b0, 4'd6},
    '{8'h38, 8'h3C, 8'h32, 1'b0, 1'b0, 4'd6},
    '{8'hB8, 8'h38, 8'hB8, 1'b0, 1'b0, 4'd6},
    '{8'h3E, 8'h3A, 8'h3B, 1'b0, 1'b0, 4'd6},
    '{8'hC4, 8'h3C, 8'hC0, 1'b0, 1'b0, 4'd6}
  };

  vec_t zero_tbl [0:5] = '{
    '{8'h38, 8'h00, 8'h78, 1'b0, 1'b1, 4'd1},
    '{8'h00, 8'h38, 8'h00, 1'b0, 1'b0, 4'd1},
    '{8'h00, 8'h00, 8'h78, 1'b0, 1'b1, 4'd1},
    '{8'hB8, 8'h00, 8'hF8, 1'b0, 1'b1, 4'd1},
    '{8'h80, 8'hB8, 8'h00, 1'b0, 1'b0, 4'd1},
    '{8'h38, 8'h07, 8'h78, 1'b0, 1'b1, 4'd1}
  };

  vec_t bound_tbl [0:5] = '{
    '{8'h70, 8'h08, 8'h78, 1'b1, 1'b0, 4'd6},
    '{8'h70, 8'h38, 8'h70, 1'b0, 1'b0, 4'd6},
    '{8'h78, 8'h38, 8'h78, 1'b1, 1'b0, 4'd6},
    '{8'h38, 8'h64, 8'h0A, 1'b0, 1'b0, 4'd6},
    '{8'h38, 8'h6C, 8'h00, 1'b1, 1'b0, 4'd6},
    '{8'h08, 8'h70, 8'h00, 1'b1, 1'b0, 4'd6}
  };

  // Stimulus only: presents one operand pair from IDLE, waits (bounded) for
  // the result, and completes the handshake if out_ready is high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rz, output logic rof, output logic rdz,
                       output int lat);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rz  = z;
    rof = of;
    rdz = dz;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = 8'h00;
    y = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (z !== 8'h00) $display("FAIL reset_z: got %h expected 00", z); else n_pass++;
    n_checks++; if ({of, dz} !== 2'b00) $display("FAIL reset_flags: got of=%b dz=%b expected 0 0", of, dz); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    $display("reset: out_valid=%b z=%h in_ready=%b", out_valid, z, in_ready);
  endtask

  task automatic test_divide();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(div_tbl[i].a, div_tbl[i].b, rz, rof, rdz, lat);
      $display("divide %h / %h -> z=%h of=%b dz=%b lat=%0d", div_tbl[i].a, div_tbl[i].b, rz, rof, rdz, lat);
      n_checks++; if (rz !== div_tbl[i].z) $display("FAIL divide_z[%0d]: got %h expected %h", i, rz, div_tbl[i].z); else n_pass++;
      n_checks++; if (rof !== div_tbl[i].of_e) $display("FAIL divide_of[%0d]: got %b expected %b", i, rof, div_tbl[i].of_e); else n_pass++;
      n_checks++; if (rdz !== div_tbl[i].dz_e) $display("FAIL divide_dz[%0d]: got %b expected %b", i, rdz, div_tbl[i].dz_e); else n_pass++;
      n_checks++; if (lat != int'(div_tbl[i].lat)) $display("FAIL divide_lat[%0d]: got %0d expected %0d", i, lat, div_tbl[i].lat); else n_pass++;
    end
  endtask

  task automatic test_zero();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(zero_tbl[i].a, zero_tbl[i].b, rz, rof, rdz, lat);
      $display("zero %h / %h -> z=%h of=%b dz=%b lat=%0d", zero_tbl[i].a, zero_tbl[i].b, rz, rof, rdz, lat);
      n_checks++; if (rz !== zero_tbl[i].z) $display("FAIL zero_z[%0d]: got %h expected %h", i, rz, zero_tbl[i].z); else n_pass++;
      n_checks++; if (rof !== zero_tbl[i].of_e) $display("FAIL zero_of[%0d]: got %b expected %b", i, rof, zero_tbl[i].of_e); else n_pass++;
      n_checks++; if (rdz !== zero_tbl[i].dz_e) $display("FAIL zero_dz[%0d]: got %b expected %b", i, rdz, zero_tbl[i].dz_e); else n_pass++;
      n_checks++; if (lat != int'(zero_tbl[i].lat)) $display("FAIL zero_lat[%0d]: got %0d expected %0d", i, lat, zero_tbl[i].lat); else n_pass++;
    end
  endtask

  task automatic test_bounds();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(bound_tbl[i].a, bound_tbl[i].b, rz, rof, rdz, lat);
      $display("bounds %h / %h -> z=%h of=%b dz=%b lat=%0d", bound_tbl[i].a, bound_tbl[i].b, rz, rof, rdz, lat);
      n_checks++; if (rz !== bound_tbl[i].z) $display("FAIL bounds_z[%0d]: got %h expected %h", i, rz, bound_tbl[i].z); else n_pass++;
      n_checks++; if (rof !== bound_tbl[i].of_e) $display("FAIL bounds_of[%0d]: got %b expected %b", i, rof, bound_tbl[i].of_e); else n_pass++;
      n_checks++; if (rdz !== bound_tbl[i].dz_e) $display("FAIL bounds_dz[%0d]: got %b expected %b", i, rdz, bound_tbl[i].dz_e); else n_pass++;
      n_checks++; if (lat != int'(bound_tbl[i].lat)) $display("FAIL bounds_lat[%0d]: got %0d expected %0d", i, lat, bound_tbl[i].lat); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    out_ready = 1'b0;
    do_op(8'h44, 8'h3C, rz, rof, rdz, lat);
    $display("stall 44 / 3C -> z=%h lat=%0d", rz, lat);
    n_checks++; if (rz !== 8'h40) $display("FAIL stall_z: got %h expected 40", rz); else n_pass++;
    n_checks++; if (lat != 6) $display("FAIL stall_lat: got %0d expected 6", lat); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        x = 8'h38;
        y = 8'h00;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, dz, of, z} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h40})
        $display("FAIL stall_hold[%0d]: got ov=%b ir=%b dz=%b of=%b z=%h expected 1 0 0 0 40",
                 i, out_valid, in_ready, dz, of, z);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL stall_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
    else n_pass++;
    in_valid = 1'b0;
    do_op(8'h38, 8'h3C, rz, rof, rdz, lat);
    $display("stall follow-up 38 / 3C -> z=%h dz=%b", rz, rdz);
    n_checks++; if ({rz, rdz} !== {8'h32, 1'b0}) $display("FAIL stall_next: got z=%h dz=%b expected 32 0", rz, rdz); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    logic seen;
    x = 8'h44;
    y = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({out_valid, in_ready, z} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL midreset_state: got ov=%b ir=%b z=%h expected 0 1 00", out_valid, in_ready, z);
    else n_pass++;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midreset_no_result: got out_valid seen=%b expected 0", seen); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", in_ready); else n_pass++;
    do_op(8'h3E, 8'h3A, rz, rof, rdz, lat);
    $display("midreset follow-up 3E / 3A -> z=%h of=%b lat=%0d", rz, rof, lat);
    n_checks++; if ({rz, rof} !== {8'h3B, 1'b0}) $display("FAIL midreset_next: got z=%h of=%b expected 3B 0", rz, rof); else n_pass++;
    n_checks++; if (lat != 6) $display("FAIL midreset_lat: got %0d expected 6", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rz;
    logic rof, rdz;
    int lat;
    logic [7:0] av [0:2];
    logic [7:0] bv [0:2];
    logic [7:0] zv [0:2];
    av = '{8'hB8, 8'h4C, 8'hC4};
    bv = '{8'hB8, 8'h44, 8'h3C};
    zv = '{8'h38, 8'h40, 8'hC0};
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], rz, rof, rdz, lat);
      $display("b2b %h / %h -> z=%h lat=%0d", av[i], bv[i], rz, lat);
      n_checks++; if (rz !== zv[i]) $display("FAIL b2b_z[%0d]: got %h expected %h", i, rz, zv[i]); else n_pass++;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL b2b_idle[%0d]: got ov=%b ir=%b expected 0 1", i, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_zero();
    test_bounds();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 ns");
    $fatal(1);
  end

endmodule
